// File: rtl/imem_loadable_if.sv
// Program-load and fetch handshake bundle for imem_loadable.
// master = boot loader / fetch stage side, slave = memory side.
interface imem_loadable_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned PC_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  reload_i;
  logic                  prog_valid_i;
  logic                  prog_ready_o;
  logic [DATA_WIDTH-1:0] prog_data_i;
  logic                  prog_last_i;
  logic                  run_o;
  logic [ADDR_WIDTH:0]   loaded_words_o;
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [PC_WIDTH-1:0]   addr_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] instr_o;
  logic                  fault_o;

  modport master (
    output reload_i, prog_valid_i, prog_data_i, prog_last_i,
           req_valid_i, addr_i, rsp_ready_i,
    input  prog_ready_o, run_o, loaded_words_o, req_ready_o,
           rsp_valid_o, instr_o, fault_o
  );

  modport slave (
    input  reload_i, prog_valid_i, prog_data_i, prog_last_i,
           req_valid_i, addr_i, rsp_ready_i,
    output prog_ready_o, run_o, loaded_words_o, req_ready_o,
           rsp_valid_o, instr_o, fault_o
  );
endinterface

// File: rtl/imem_loadable.sv
// Loadable instruction memory: zero-fill after reset, streamed program load,
// then one-cycle-latency fetch with a single-entry response register.
module imem_loadable #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned PC_WIDTH   = 16,
  parameter int unsigned ADDR_SHIFT = 2,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input logic            clk_i,
  input logic            rst_ni,
  imem_loadable_if.slave bus
);

  localparam int unsigned CMP_W = PC_WIDTH + 32;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH:0]   r_loaded;
  logic                  r_run;
  logic                  r_prog_ready;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_instr;
  logic                  r_fault;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_last_slot;
  logic                  w_prog_fire;
  logic                  w_mem_we;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic                  w_req_ready;
  logic                  w_req_fire;
  logic [PC_WIDTH-1:0]   w_word;
  logic                  w_fault;
  logic [ADDR_WIDTH-1:0] w_rd_idx;

  assign w_last_slot = (r_wptr == ADDR_WIDTH'(DEPTH - 1));
  assign w_prog_fire = (r_state == ST_LOAD) && bus.prog_valid_i;
  assign w_mem_we    = (r_state == ST_CLEAR) || w_prog_fire;
  assign w_mem_wdata = (r_state == ST_CLEAR) ? '0 : bus.prog_data_i;

  // Response slot frees up when empty or being drained this cycle.
  assign w_req_ready = r_run && (!r_rsp_valid || bus.rsp_ready_i);
  assign w_req_fire  = bus.req_valid_i && w_req_ready;
  assign w_word      = bus.addr_i >> ADDR_SHIFT;
  assign w_fault     = (CMP_W'(w_word) >= CMP_W'(DEPTH)) ||
                       (bus.addr_i[ADDR_SHIFT-1:0] != '0);
  assign w_rd_idx    = ADDR_WIDTH'(w_word);

  // Array has no reset; CLEAR zero-fills it instead.
  always_ff @(posedge clk_i) begin
    if (w_mem_we) r_mem[r_wptr] <= w_mem_wdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_CLEAR;
      r_wptr       <= '0;
      r_loaded     <= '0;
      r_run        <= 1'b0;
      r_prog_ready <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_instr      <= '0;
      r_fault      <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_wptr <= r_wptr + ADDR_WIDTH'(1);
          if (w_last_slot) begin
            r_wptr       <= '0;
            r_state      <= ST_LOAD;
            r_prog_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (bus.prog_valid_i) begin
            r_wptr   <= r_wptr + ADDR_WIDTH'(1);
            r_loaded <= (ADDR_WIDTH + 1)'(r_wptr) + (ADDR_WIDTH + 1)'(1);
            // A full memory ends the load even without a last marker.
            if (bus.prog_last_i || w_last_slot) begin
              r_wptr       <= '0;
              r_state      <= ST_RUN;
              r_prog_ready <= 1'b0;
              r_run        <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (bus.reload_i) begin
            r_state     <= ST_CLEAR;
            r_wptr      <= '0;
            r_run       <= 1'b0;
            r_rsp_valid <= 1'b0;
          end else if (w_req_fire) begin
            r_rsp_valid <= 1'b1;
            r_instr     <= w_fault ? '0 : r_mem[w_rd_idx];
            r_fault     <= w_fault;
          end else if (bus.rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

  assign bus.prog_ready_o   = r_prog_ready;
  assign bus.run_o          = r_run;
  assign bus.loaded_words_o = r_loaded;
  assign bus.req_ready_o    = w_req_ready;
  assign bus.rsp_valid_o    = r_rsp_valid;
  assign bus.instr_o        = r_instr;
  assign bus.fault_o        = r_fault;

endmodule

// File: tb/tb_imem_loadable.sv
// Bench for imem_loadable (DEPTH=8): directed load/fetch/fault/reload cases
// plus randomized fetch traffic scored against an array/queue reference model.
module tb_imem_loadable;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned PCW   = 16;
  localparam int unsigned SH    = 2;
  localparam int unsigned AW    = 3;

  typedef struct {
    logic [DW-1:0] instr;
    logic          fault;
  } rsp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_loadable_if #(.DATA_WIDTH(DW), .PC_WIDTH(PCW), .ADDR_WIDTH(AW)) bus ();

  imem_loadable #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .PC_WIDTH(PCW), .ADDR_SHIFT(SH), .ADDR_WIDTH(AW)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW-1:0] stim [$];
  rsp_t          sb [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Memory behaviour stated directly: word index, range and stride alignment.
  function automatic rsp_t model_fetch(input logic [PCW-1:0] a);
    rsp_t r;
    int unsigned ai   = 32'(a);
    int unsigned word = ai / (1 << SH);
    if (word >= DEPTH || (ai % (1 << SH)) != 0) begin
      r.instr = '0;
      r.fault = 1'b1;
    end else begin
      r.instr = exp_mem[word];
      r.fault = 1'b0;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_phase(input string tag);
    for (int i = 0; i < int'(DEPTH); i++) begin
      check($sformatf("%s_ready_c%0d", tag, i), 32'(bus.prog_ready_o), 32'd0);
      check($sformatf("%s_run_c%0d", tag, i), 32'(bus.run_o), 32'd0);
      step();
    end
    check($sformatf("%s_ready_load", tag), 32'(bus.prog_ready_o), 32'd1);
    for (int i = 0; i < int'(DEPTH); i++) exp_mem[i] = '0;
  endtask

  task automatic load_stim(input string tag, input bit use_last);
    for (int i = 0; i < stim.size(); i++) begin
      check($sformatf("%s_pready%0d", tag, i), 32'(bus.prog_ready_o), 32'd1);
      bus.prog_valid_i = 1'b1;
      bus.prog_data_i  = stim[i];
      bus.prog_last_i  = use_last && (i == stim.size() - 1);
      step();
      exp_mem[i] = stim[i];
    end
    bus.prog_valid_i = 1'b0;
    bus.prog_last_i  = 1'b0;
    check({tag, "_run"}, 32'(bus.run_o), 32'd1);
    check({tag, "_loaded"}, 32'(bus.loaded_words_o), 32'(stim.size()));
  endtask

  task automatic fetch_one(input logic [PCW-1:0] a);
    rsp_t e;
    e = model_fetch(a);
    bus.req_valid_i = 1'b1;
    bus.addr_i      = a;
    bus.rsp_ready_i = 1'b1;
    #1;
    check($sformatf("req_ready_%0h", a), 32'(bus.req_ready_o), 32'd1);
    step();
    bus.req_valid_i = 1'b0;
    check($sformatf("rsp_valid_%0h", a), 32'(bus.rsp_valid_o), 32'd1);
    check($sformatf("instr_%0h", a), 32'(bus.instr_o), 32'(e.instr));
    check($sformatf("fault_%0h", a), 32'(bus.fault_o), 32'(e.fault));
    step();
    check($sformatf("drain_%0h", a), 32'(bus.rsp_valid_o), 32'd0);
  endtask

  // bp=1: requests held valid and the consumer stalls on cycles 1..3.
  task automatic stream(input string tag, input int n, input bit bp);
    logic [PCW-1:0] a;
    bit consumed, accepted;
    for (int c = 0; c < n; c++) begin
      a = PCW'($urandom_range(0, 'h27));
      bus.req_valid_i = bp ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      bus.addr_i      = a;
      bus.rsp_ready_i = bp ? 1'(!(c >= 1 && c <= 3)) : 1'($urandom_range(0, 3) != 0);
      #1;
      check($sformatf("%s_valid%0d", tag, c), 32'(bus.rsp_valid_o), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
        check($sformatf("%s_instr%0d", tag, c), 32'(bus.instr_o), 32'(sb[0].instr));
        check($sformatf("%s_fault%0d", tag, c), 32'(bus.fault_o), 32'(sb[0].fault));
      end
      check($sformatf("%s_rready%0d", tag, c), 32'(bus.req_ready_o),
            32'(sb.size() == 0 || bus.rsp_ready_i));
      consumed = bus.rsp_valid_o && bus.rsp_ready_i;
      accepted = bus.req_valid_i && bus.req_ready_o;
      step();
      if (consumed && sb.size() != 0) void'(sb.pop_front());
      if (accepted) sb.push_back(model_fetch(a));
    end
    bus.req_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    #1;
    check({tag, "_tail_valid"}, 32'(bus.rsp_valid_o), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      check({tag, "_tail_instr"}, 32'(bus.instr_o), 32'(sb[0].instr));
      check({tag, "_tail_fault"}, 32'(bus.fault_o), 32'(sb[0].fault));
    end
    step();
    sb.delete();
    check({tag, "_idle"}, 32'(bus.rsp_valid_o), 32'd0);
  endtask

  initial begin
    bus.reload_i     = 1'b0;
    bus.prog_valid_i = 1'b0;
    bus.prog_data_i  = '0;
    bus.prog_last_i  = 1'b0;
    bus.req_valid_i  = 1'b0;
    bus.addr_i       = '0;
    bus.rsp_ready_i  = 1'b0;

    #12;
    check("rst_run",    32'(bus.run_o),          32'd0);
    check("rst_pready", 32'(bus.prog_ready_o),   32'd0);
    check("rst_rready", 32'(bus.req_ready_o),    32'd0);
    check("rst_rvalid", 32'(bus.rsp_valid_o),    32'd0);
    check("rst_instr",  32'(bus.instr_o),        32'd0);
    check("rst_fault",  32'(bus.fault_o),        32'd0);
    check("rst_loaded", 32'(bus.loaded_words_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_phase("clr0");

    stim = '{16'h1298, 16'h0850, 16'h2642, 16'h3283};
    load_stim("ld4", 1'b1);
    for (int i = 0; i <= 4; i++) fetch_one(PCW'(i * 4));
    fetch_one(16'h0020);
    fetch_one(16'h0006);
    fetch_one(16'h001C);
    stream("rnd1", 40, 1'b0);
    stream("bp", 8, 1'b1);

    // Leave a response pending, then reload over it.
    bus.req_valid_i = 1'b1;
    bus.addr_i      = 16'h0004;
    bus.rsp_ready_i = 1'b0;
    step();
    bus.req_valid_i = 1'b0;
    check("pend_valid", 32'(bus.rsp_valid_o), 32'd1);
    bus.reload_i = 1'b1;
    step();
    bus.reload_i = 1'b0;
    check("rl_rvalid", 32'(bus.rsp_valid_o), 32'd0);
    check("rl_run",    32'(bus.run_o),       32'd0);
    clear_phase("clr1");

    stim.delete();
    for (int i = 0; i < int'(DEPTH); i++) stim.push_back(DW'($urandom));
    load_stim("full", 1'b0);
    bus.prog_valid_i = 1'b1;
    bus.prog_data_i  = 16'hFFFF;
    #1;
    check("ninth_pready", 32'(bus.prog_ready_o), 32'd0);
    step();
    bus.prog_valid_i = 1'b0;
    check("ninth_loaded", 32'(bus.loaded_words_o), 32'(DEPTH));
    for (int i = 0; i < int'(DEPTH); i++) fetch_one(PCW'(i * 4));

    bus.reload_i = 1'b1;
    step();
    bus.reload_i = 1'b0;
    clear_phase("clr2");
    stim.delete();
    for (int i = 0; i < 3; i++) stim.push_back(DW'($urandom));
    load_stim("ld3", 1'b1);
    for (int i = 0; i < int'(DEPTH); i++) fetch_one(PCW'(i * 4));
    stream("rnd2", 30, 1'b0);

    // Asynchronous reset with a response outstanding.
    bus.req_valid_i = 1'b1;
    bus.addr_i      = 16'h0000;
    bus.rsp_ready_i = 1'b0;
    step();
    bus.req_valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_rvalid", 32'(bus.rsp_valid_o),    32'd0);
    check("mrst_run",    32'(bus.run_o),          32'd0);
    check("mrst_instr",  32'(bus.instr_o),        32'd0);
    check("mrst_loaded", 32'(bus.loaded_words_o), 32'd0);
    check("mrst_rready", 32'(bus.req_ready_o),    32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
